// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI HS transmit controller: state encoding,
// the HS sync byte and the default timing counts (in byte clocks).
package mipi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LPX     = 3'd1,
    ST_PREPARE = 3'd2,
    ST_HS_ZERO = 3'd3,
    ST_SYNC    = 3'd4,
    ST_DATA    = 3'd5,
    ST_TRAIL   = 3'd6,
    ST_EXIT    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam int DEF_T_LPX        = 4;
  localparam int DEF_T_HS_PREPARE = 3;
  localparam int DEF_T_HS_ZERO    = 6;
  localparam int DEF_T_HS_TRAIL   = 4;
  localparam int DEF_T_HS_EXIT    = 5;

  // All timing counts fit in 1..255.
  localparam int TMR_W = 8;

endpackage

// File: rtl/mipi_hstx_timer.sv
// Duration down-counter: loaded on entry to a timed state, counts down once
// per byte clock, and flags the last cycle of the state with done.
module mipi_hstx_timer
  import mipi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Load wins; otherwise count down and rest at zero outside timed states.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 means the current cycle is the last one of the state.
  assign done = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/mipi_hstx_ctrl.sv
// MIPI D-PHY HS transmit sequencer: walks LP-11 -> LP-01 -> LP-00 -> HS-zero
// -> sync byte -> payload -> trail -> LP-11, driving the LP lines, the HS
// driver power-down and the serializer byte stream.
module mipi_hstx_ctrl
  import mipi_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int T_LPX        = DEF_T_LPX,
  parameter int T_HS_PREPARE = DEF_T_HS_PREPARE,
  parameter int T_HS_ZERO    = DEF_T_HS_ZERO,
  parameter int T_HS_TRAIL   = DEF_T_HS_TRAIL,
  parameter int T_HS_EXIT    = DEF_T_HS_EXIT
)(
  input  logic             HS_BYTE_CLKS,
  input  logic             HS_RSTN,
  input  logic             TXREQUESTHS,
  input  logic [WIDTH-1:0] TXDATAHS,
  output logic             TXREADYHS,
  output logic [WIDTH-1:0] HSTX_DATA,
  output logic             HS_SER_EN,
  output logic             TXHSPD,
  output logic             LP_P,
  output logic             LP_N,
  output logic             STOPSTATE
);

  localparam logic [WIDTH-1:0] SYNC_W = WIDTH'(SYNC_BYTE);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] hs_data_q;
  logic [WIDTH-1:0] hs_data_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  mipi_hstx_timer u_timer (
    .clk      (HS_BYTE_CLKS),
    .rst_n    (HS_RSTN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state; the timer is reloaded whenever a timed state is entered.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE:    if (TXREQUESTHS) state_d = ST_LPX;
      ST_LPX:     if (tmr_done) state_d = ST_PREPARE;
      ST_PREPARE: if (tmr_done) state_d = ST_HS_ZERO;
      ST_HS_ZERO: if (tmr_done) state_d = ST_SYNC;
      ST_SYNC,
      ST_DATA:    state_d = TXREQUESTHS ? ST_DATA : ST_TRAIL;
      ST_TRAIL:   if (tmr_done) state_d = ST_EXIT;
      ST_EXIT:    if (tmr_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        ST_LPX:     begin tmr_load = 1'b1; tmr_val = TMR_W'(T_LPX);        end
        ST_PREPARE: begin tmr_load = 1'b1; tmr_val = TMR_W'(T_HS_PREPARE); end
        ST_HS_ZERO: begin tmr_load = 1'b1; tmr_val = TMR_W'(T_HS_ZERO);    end
        ST_TRAIL:   begin tmr_load = 1'b1; tmr_val = TMR_W'(T_HS_TRAIL);   end
        ST_EXIT:    begin tmr_load = 1'b1; tmr_val = TMR_W'(T_HS_EXIT);    end
        default:    ;
      endcase
    end
  end

  // Serializer byte for the next cycle: the accepted payload byte appears
  // one cycle after its handshake; the trail byte is the opposite of the
  // last driven MSB and is frozen for the whole trail.
  always_comb begin
    hs_data_d = '0;
    case (state_d)
      ST_SYNC:  hs_data_d = SYNC_W;
      ST_DATA:  hs_data_d = TXDATAHS;
      ST_TRAIL: begin
        if (state_q == ST_TRAIL) begin
          hs_data_d = hs_data_q;
        end else begin
          hs_data_d = hs_data_q[WIDTH-1] ? '0 : '1;
        end
      end
      default:  hs_data_d = '0;
    endcase
  end

  // State and serializer byte registers; reset aborts any burst at once.
  always_ff @(posedge HS_BYTE_CLKS or negedge HS_RSTN) begin
    if (!HS_RSTN) begin
      state_q   <= ST_IDLE;
      hs_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hs_data_q <= hs_data_d;
    end
  end

  // Line levels and enables decoded from the current state.
  always_comb begin
    LP_P      = 1'b1;
    LP_N      = 1'b1;
    TXHSPD    = 1'b1;
    HS_SER_EN = 1'b0;
    STOPSTATE = 1'b0;
    case (state_q)
      ST_IDLE:    STOPSTATE = 1'b1;
      ST_LPX:     LP_P = 1'b0;
      ST_PREPARE: begin LP_P = 1'b0; LP_N = 1'b0; TXHSPD = 1'b0; end
      ST_HS_ZERO,
      ST_SYNC,
      ST_DATA,
      ST_TRAIL:   begin LP_P = 1'b0; LP_N = 1'b0; TXHSPD = 1'b0; HS_SER_EN = 1'b1; end
      default:    ;
    endcase
  end

  assign TXREADYHS = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && TXREQUESTHS;
  assign HSTX_DATA = hs_data_q;

endmodule

// File: tb/tb_mipi_hstx_ctrl.sv
// Bench for mipi_hstx_ctrl: a default-timed instance and a short-timed
// instance, driven with directed and random bursts; every cycle's outputs
// are compared with a sequence derived from the burst description.
module tb_mipi_hstx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic [1:0]       req_i;
  logic [1:0][7:0]  dat_i;
  logic [1:0][13:0] obs;

  logic       rdy_a, ser_a, hspd_a, lpp_a, lpn_a, stop_a;
  logic [7:0] hd_a;
  logic       rdy_b, ser_b, hspd_b, lpp_b, lpn_b, stop_b;
  logic [7:0] hd_b;

  mipi_hstx_ctrl u_dut_a (
    .HS_BYTE_CLKS (clk),
    .HS_RSTN      (rstn),
    .TXREQUESTHS  (req_i[0]),
    .TXDATAHS     (dat_i[0]),
    .TXREADYHS    (rdy_a),
    .HSTX_DATA    (hd_a),
    .HS_SER_EN    (ser_a),
    .TXHSPD       (hspd_a),
    .LP_P         (lpp_a),
    .LP_N         (lpn_a),
    .STOPSTATE    (stop_a)
  );

  mipi_hstx_ctrl #(
    .T_LPX      (1),
    .T_HS_ZERO  (1),
    .T_HS_TRAIL (1)
  ) u_dut_b (
    .HS_BYTE_CLKS (clk),
    .HS_RSTN      (rstn),
    .TXREQUESTHS  (req_i[1]),
    .TXDATAHS     (dat_i[1]),
    .TXREADYHS    (rdy_b),
    .HSTX_DATA    (hd_b),
    .HS_SER_EN    (ser_b),
    .TXHSPD       (hspd_b),
    .LP_P         (lpp_b),
    .LP_N         (lpn_b),
    .STOPSTATE    (stop_b)
  );

  // Observed word layout: {LP_P, LP_N, TXHSPD, HS_SER_EN, STOPSTATE, TXREADYHS, HSTX_DATA}
  assign obs[0] = {lpp_a, lpn_a, hspd_a, ser_a, stop_a, rdy_a, hd_a};
  assign obs[1] = {lpp_b, lpn_b, hspd_b, ser_b, stop_b, rdy_b, hd_b};

  int n_vec = 0;
  int n_err = 0;
  int hs    = 0;
  logic [7:0] pay[$];

  // Timing of each instance, in byte clocks.
  function automatic int t_lpx(input int u);   return (u == 0) ? 4 : 1; endfunction
  function automatic int t_prep(input int u);  return 3;                endfunction
  function automatic int t_zero(input int u);  return (u == 0) ? 6 : 1; endfunction
  function automatic int t_trail(input int u); return (u == 0) ? 4 : 1; endfunction
  function automatic int t_exit(input int u);  return 5;                endfunction

  function automatic logic [13:0] ew(input logic [1:0] lp, input logic hspd, input logic ser,
                                     input logic stop, input logic rdy, input logic [7:0] d);
    return {lp, hspd, ser, stop, rdy, d};
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_vec++;
    if (obs_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs_v, exp_v, $time);
    end
  endtask

  // One byte clock: drive inputs after the falling edge, check just after.
  task automatic step(input int u, input logic r, input logic [7:0] d,
                      input logic [13:0] e, input string tag);
    @(negedge clk);
    req_i[u] = r;
    dat_i[u] = d;
    #1;
    chk(tag, 32'(obs[u]), 32'(e));
    if (obs[u][8] && r) hs++;
  endtask

  task automatic gap(input int u, input int g);
    for (int i = 0; i < g; i++) step(u, 1'b0, rb(), ew(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00), "idle");
  endtask

  // One burst of n payload bytes taken from pay. With rnd_side set, the
  // request is randomised wherever it must be ignored (preamble, trail,
  // exit); otherwise it stays high through the preamble only when there
  // is payload. abort_at >= 0 pulls reset during that payload cycle.
  task automatic burst(input int u, input int n, input int abort_at, input bit rnd_side);
    logic [7:0] last;
    logic [7:0] trail_b;
    logic       pre_r;
    hs = 0;
    pre_r = (n > 0);
    step(u, 1'b1, rb(), ew(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00), "idle_req");
    for (int i = 0; i < t_lpx(u); i++)
      step(u, rnd_side ? rbit() : pre_r, rb(), ew(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), "lpx");
    for (int i = 0; i < t_prep(u); i++)
      step(u, rnd_side ? rbit() : pre_r, rb(), ew(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00), "prepare");
    for (int i = 0; i < t_zero(u); i++)
      step(u, rnd_side ? rbit() : pre_r, rb(), ew(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00), "hs_zero");
    step(u, n > 0, (n > 0) ? pay[0] : rb(), ew(2'b00, 1'b0, 1'b1, 1'b0, n > 0, 8'hB8), "sync");
    last = 8'hB8;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        req_i[u] = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_abort", 32'(obs[u]), 32'(ew(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
        @(negedge clk);
        req_i[u] = 1'b0;
        rstn = 1'b1;
        return;
      end
      step(u, (i + 1) < n, ((i + 1) < n) ? pay[i+1] : rb(),
           ew(2'b00, 1'b0, 1'b1, 1'b0, (i + 1) < n, pay[i]), "data");
      last = pay[i];
    end
    trail_b = last[7] ? 8'h00 : 8'hFF;
    for (int i = 0; i < t_trail(u); i++)
      step(u, rnd_side ? rbit() : 1'b0, rb(), ew(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, trail_b), "trail");
    for (int i = 0; i < t_exit(u); i++)
      step(u, rnd_side ? rbit() : 1'b0, rb(), ew(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00), "exit");
    chk("handshakes", 32'(hs), 32'(n));
  endtask

  task automatic fill(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(rb());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn  = 1'b0;
    req_i = '0;
    dat_i = '0;
    #3;
    chk("reset_a", 32'(obs[0]), 32'(ew(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
    chk("reset_b", 32'(obs[1]), 32'(ew(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    gap(0, 2);

    // Three-byte burst, MSB of last byte clear.
    pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    burst(0, 3, -1, 1'b0);
    gap(0, 2);

    // Single byte with MSB set.
    pay.delete(); pay.push_back(8'h80);
    burst(0, 1, -1, 1'b0);
    gap(0, 1);

    // One-cycle request pulse: preamble, sync, no payload.
    burst(0, 0, -1, 1'b0);
    gap(0, 1);

    // Reset during payload, then a fresh burst.
    fill(4);
    burst(0, 4, 2, 1'b1);
    gap(0, 2);
    fill(2);
    burst(0, 2, -1, 1'b1);

    // Random bursts, back-to-back at times (request reasserted in exit).
    for (int k = 0; k < 25; k++) begin
      fill($urandom_range(5, 0));
      burst(0, pay.size(), -1, 1'b1);
      gap(0, $urandom_range(2, 0));
    end
    gap(0, 1);

    // Short-timed instance.
    gap(1, 1);
    pay.delete(); pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    burst(1, 3, -1, 1'b0);
    gap(1, 1);
    for (int k = 0; k < 8; k++) begin
      fill($urandom_range(4, 0));
      burst(1, pay.size(), -1, 1'b1);
      gap(1, $urandom_range(2, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
